// File: rtl/mem_bus_arbiter.sv
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned MAX_D_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_err_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_sel_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [3:0]        m_sel_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic              m_ack_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic              stall_req_o
);

  localparam int unsigned RUN_W  = (MAX_D_RUN < 1) ? 1 : $clog2(MAX_D_RUN + 1);
  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_D_RUN);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t              state_q,    state_d;
  logic                gnt_i_q,    gnt_i_d;
  logic [RUN_W-1:0]    run_cnt_q,  run_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic                m_req_q,    m_req_d;
  logic                m_we_q,     m_we_d;
  logic [3:0]          m_sel_q,    m_sel_d;
  logic [ADDR_W-1:0]   m_addr_q,   m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q,  m_wdata_d;

  logic                i_ack_q,    i_ack_d;
  logic [DATA_W-1:0]   i_rdata_q,  i_rdata_d;
  logic                i_err_q,    i_err_d;
  logic                d_ack_q,    d_ack_d;
  logic [DATA_W-1:0]   d_rdata_q,  d_rdata_d;
  logic                d_err_q,    d_err_d;

  logic                pick_i;
  logic                resp_go;
  logic [DATA_W-1:0]   resp_data;
  logic                resp_err;

  always_comb begin
    state_d    = state_q;
    gnt_i_d    = gnt_i_q;
    run_cnt_d  = run_cnt_q;
    wait_cnt_d = wait_cnt_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_sel_d    = m_sel_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    i_ack_d    = 1'b0;
    i_rdata_d  = i_rdata_q;
    i_err_d    = i_err_q;
    d_ack_d    = 1'b0;
    d_rdata_d  = d_rdata_q;
    d_err_d    = d_err_q;
    pick_i     = 1'b0;
    resp_go    = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req_i || d_req_i) begin
          pick_i     = i_req_i && (!d_req_i || (run_cnt_q == RUN_MAX));
          gnt_i_d    = pick_i;
          m_req_d    = 1'b1;
          wait_cnt_d = '0;
          state_d    = BUSY;
          if (pick_i) begin
            m_we_d    = 1'b0;
            m_sel_d   = '1;
            m_addr_d  = i_addr_i;
            m_wdata_d = '0;
            run_cnt_d = '0;
          end else begin
            m_we_d    = d_we_i;
            m_sel_d   = d_sel_i;
            m_addr_d  = d_addr_i;
            m_wdata_d = d_wdata_i;
            if (!i_req_i) begin
              run_cnt_d = '0;
            end else if (run_cnt_q != RUN_MAX) begin
              run_cnt_d = run_cnt_q + 1'b1;
            end
          end
        end
      end

      BUSY: begin
        if (m_ack_i) begin
          resp_go   = 1'b1;
          resp_data = m_rdata_i;
        end else if (wait_cnt_q == WAIT_LAST) begin
          resp_go  = 1'b1;
          resp_err = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end

        // Response registers load on the BUSY exit edge so ack/rdata/err are
        // flop outputs during the RESP cycle.
        if (resp_go) begin
          m_req_d = 1'b0;
          state_d = RESP;
          if (gnt_i_q) begin
            i_ack_d   = 1'b1;
            i_rdata_d = resp_data;
            i_err_d   = resp_err;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = resp_data;
            d_err_d   = resp_err;
          end
        end
      end

      RESP: begin
        i_rdata_d = '0;
        i_err_d   = 1'b0;
        d_rdata_d = '0;
        d_err_d   = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_i_q    <= 1'b0;
      run_cnt_q  <= '0;
      wait_cnt_q <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_sel_q    <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_ack_q    <= 1'b0;
      i_rdata_q  <= '0;
      i_err_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      d_rdata_q  <= '0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_i_q    <= gnt_i_d;
      run_cnt_q  <= run_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_sel_q    <= m_sel_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_ack_q    <= i_ack_d;
      i_rdata_q  <= i_rdata_d;
      i_err_q    <= i_err_d;
      d_ack_q    <= d_ack_d;
      d_rdata_q  <= d_rdata_d;
      d_err_q    <= d_err_d;
    end
  end

  assign m_req_o     = m_req_q;
  assign m_we_o      = m_we_q;
  assign m_sel_o     = m_sel_q;
  assign m_addr_o    = m_addr_q;
  assign m_wdata_o   = m_wdata_q;
  assign i_ack_o     = i_ack_q;
  assign i_rdata_o   = i_rdata_q;
  assign i_err_o     = i_err_q;
  assign d_ack_o     = d_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_err_o     = d_err_q;
  assign stall_req_o = (i_req_i & ~i_ack_q) | (d_req_i & ~d_ack_q);

endmodule
